// File: rtl/pmt_sort_checker_if.sv
// pmt_sort_checker_if: merged-stream input and verdict outputs of the sort checker
interface pmt_sort_checker_if #(
  parameter int P_LOG = 3,
  parameter int RCDW  = 64
);
  logic                         din_en;
  logic [RCDW*(1<<P_LOG)-1:0]   din;
  logic [31:0]                  rcd_cnt;
  logic [31:0]                  key_sum;
  logic                         err;
  logic [31:0]                  err_idx;
  logic                         done;
  logic                         pass;
  modport master (output din_en, din, input rcd_cnt, key_sum, err, err_idx, done, pass);
  modport slave  (input din_en, din, output rcd_cnt, key_sum, err, err_idx, done, pass);
endinterface

// File: rtl/pmt_sort_checker.sv
// pmt_sort_checker: two-stage on-the-fly order check, record count and key checksum of the merged stream
module pmt_sort_checker #(
  parameter int P_LOG   = 3,
  parameter int RCDW    = 64,
  parameter int KEYW    = 32,
  parameter int RCD_NUM = 1024
) (
  input logic CLK,
  input logic RST,
  pmt_sort_checker_if.slave bus
);
  localparam int P = 1 << P_LOG;
  typedef enum logic {RUN, DONE} state_t;
  state_t          state;
  logic            accept;
  logic            stop_in;
  logic            s1_vld;
  logic            err;
  logic [KEYW-1:0] key [P];
  logic [KEYW-1:0] s1_key [P];
  logic [KEYW-1:0] last_key;
  logic [P-1:0]    intra;
  logic [P-1:0]    s1_intra;
  logic [P-1:0]    v;
  logic [31:0]     t [P];
  logic [31:0]     acc_cnt;
  logic [31:0]     s1_base;
  logic [31:0]     s1_sum;
  logic [31:0]     rcd_cnt;
  logic [31:0]     key_sum;
  logic [31:0]     err_idx;
  logic [31:0]     off;
  assign accept = bus.din_en && state == RUN && !stop_in;
  // intra[k] flags record k below record k-1; bit 0 is reserved for the cross-word compare
  always_comb begin
    intra = '0;
    for (int k = 0; k < P; k++) begin
      key[k] = bus.din[RCDW*k +: KEYW];
      t[k]   = 32'(key[k]);
    end
    for (int k = 1; k < P; k++) intra[k] = key[k] < key[k-1];
    for (int l = 0; l < P_LOG; l++)
      for (int i = 0; i < P/2; i++)
        if (i < (P >> (l + 1))) t[i] = t[2*i] + t[2*i+1];
  end
  always_comb begin
    v    = s1_intra;
    v[0] = s1_base != 32'd0 && s1_key[0] < last_key;
    off  = '0;
    for (int k = P - 1; k >= 0; k--) if (v[k]) off = 32'(k);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      stop_in  <= 1'b0;
      s1_vld   <= 1'b0;
      err      <= 1'b0;
      s1_key   <= '{default: '0};
      last_key <= '0;
      s1_intra <= '0;
      acc_cnt  <= '0;
      s1_base  <= '0;
      s1_sum   <= '0;
      rcd_cnt  <= '0;
      key_sum  <= '0;
      err_idx  <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        acc_cnt  <= acc_cnt + 32'(P);
        stop_in  <= stop_in || acc_cnt + 32'(P) == 32'(RCD_NUM);
        s1_key   <= key;
        s1_intra <= intra;
        s1_sum   <= t[0];
        s1_base  <= acc_cnt;
      end
      if (s1_vld) begin
        last_key <= s1_key[P-1];
        rcd_cnt  <= rcd_cnt + 32'(P);
        key_sum  <= key_sum + s1_sum;
        if (v != '0 && !err) begin
          err     <= 1'b1;
          err_idx <= s1_base + off;
        end
        if (rcd_cnt + 32'(P) == 32'(RCD_NUM)) state <= DONE;
      end
    end
  end
  assign bus.rcd_cnt = rcd_cnt;
  assign bus.key_sum = key_sum;
  assign bus.err     = err;
  assign bus.err_idx = err_idx;
  assign bus.done    = state == DONE;
  assign bus.pass    = state == DONE && !err;
endmodule

// File: tb/tb_pmt_sort_checker.sv
// tb_pmt_sort_checker: directed runs; a record-by-record model queues expected outputs, a monitor checks them on their due cycle
module tb_pmt_sort_checker;
  localparam int NREC = 1024;
  typedef struct {
    int          due;
    logic [31:0] cnt;
    logic [31:0] sum;
    logic        err;
    logic [31:0] idx;
    logic        done;
  } exp_t;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        rst_q = 1'b1;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] keys [NREC];
  logic [31:0] prev_cnt;
  exp_t        q [$];
  logic [31:0] m_cnt, m_sum, m_last, m_idx;
  logic        m_err, m_stop;
  pmt_sort_checker_if #(.P_LOG(3), .RCDW(64)) bus ();
  pmt_sort_checker #(.P_LOG(3), .RCDW(64), .KEYW(32), .RCD_NUM(NREC)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    rst_q <= RST;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask
  always @(negedge CLK) begin
    if (q.size() != 0 && q[0].due == cyc) begin
      chk("rcd_cnt", bus.rcd_cnt, q[0].cnt);
      chk("key_sum", bus.key_sum, q[0].sum);
      chk("err", 32'(bus.err), 32'(q[0].err));
      chk("err_idx", bus.err_idx, q[0].idx);
      chk("done", 32'(bus.done), 32'(q[0].done));
      chk("pass", 32'(bus.pass), 32'(q[0].done && !q[0].err));
      void'(q.pop_front());
    end else if (!rst_q && bus.rcd_cnt !== prev_cnt) begin
      chk("spurious_rcd_cnt", bus.rcd_cnt, prev_cnt);
    end
    prev_cnt <= bus.rcd_cnt;
  end
  task automatic model_clear();
    m_cnt = 0; m_sum = 0; m_last = 0; m_idx = 0; m_err = 0; m_stop = 0;
  endtask
  task automatic send(input int w);
    logic [511:0] d;
    logic [31:0]  kv;
    for (int k = 0; k < 8; k++) begin
      kv = keys[(w*8 + k) % NREC];
      d[64*k +: 64] = {~kv, kv};
    end
    bus.din    = d;
    bus.din_en = 1'b1;
    if (!m_stop) begin
      for (int k = 0; k < 8; k++) begin
        kv = keys[(w*8 + k) % NREC];
        if (m_cnt != 0 && kv < m_last && !m_err) begin
          m_err = 1'b1;
          m_idx = m_cnt;
        end
        m_last = kv;
        m_cnt  = m_cnt + 1;
        m_sum  = m_sum + kv;
      end
      if (m_cnt == NREC) m_stop = 1'b1;
      q.push_back('{cyc + 2, m_cnt, m_sum, m_err, m_idx, m_stop});
    end
    @(posedge CLK);
    #1;
    bus.din_en = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic do_reset();
    RST = 1'b1;
    bus.din_en = 1'b0;
    while (q.size() != 0 && q[$].due > cyc) void'(q.pop_back());
    model_clear();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst_rcd_cnt", bus.rcd_cnt, 0);
    chk("rst_key_sum", bus.key_sum, 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_err_idx", bus.err_idx, 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pass", 32'(bus.pass), 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge CLK);
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge CLK);
    #1;
  endtask
  task automatic set_asc();
    for (int i = 0; i < NREC; i++) keys[i] = i + 1;
  endtask
  task automatic run(input bit gaps);
    for (int w = 0; w < 128; w++) begin
      send(w);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask
  initial begin
    bus.din_en = 1'b0;
    bus.din    = '0;
    model_clear();
    idle(2);
    do_reset();
    set_asc();
    run(1'b0);
    drain();
    chk("asc_rcd_cnt", bus.rcd_cnt, 1024);
    chk("asc_key_sum", bus.key_sum, 524800);
    chk("asc_err", 32'(bus.err), 0);
    chk("asc_pass", 32'(bus.pass), 1);
    do_reset();
    run(1'b1);
    for (int w = 0; w < 10; w++) send(w);
    drain();
    chk("gap_extra_rcd_cnt", bus.rcd_cnt, 1024);
    chk("gap_extra_key_sum", bus.key_sum, 524800);
    chk("gap_extra_pass", 32'(bus.pass), 1);
    do_reset();
    keys[37]  = 30;
    keys[900] = 5;
    run(1'b0);
    drain();
    chk("intra_err", 32'(bus.err), 1);
    chk("intra_err_idx", bus.err_idx, 37);
    chk("intra_pass", 32'(bus.pass), 0);
    chk("intra_done", 32'(bus.done), 1);
    do_reset();
    set_asc();
    keys[40] = 39;
    run(1'b0);
    drain();
    chk("cross_err_idx", bus.err_idx, 40);
    chk("cross_pass", 32'(bus.pass), 0);
    do_reset();
    keys[40] = 40;
    run(1'b0);
    drain();
    chk("equal_err", 32'(bus.err), 0);
    chk("equal_pass", 32'(bus.pass), 1);
    do_reset();
    set_asc();
    keys[15] = 32'hFFFF_FFFF;
    run(1'b0);
    drain();
    chk("unsigned_err_idx", bus.err_idx, 16);
    chk("unsigned_err", 32'(bus.err), 1);
    do_reset();
    set_asc();
    for (int w = 0; w < 60; w++) send(w);
    do_reset();
    run(1'b0);
    drain();
    chk("rerun_rcd_cnt", bus.rcd_cnt, 1024);
    chk("rerun_key_sum", bus.key_sum, 524800);
    chk("rerun_pass", 32'(bus.pass), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
